score_bcd_display: RTL

//   Downstream of the score accumulator in the game top level. Takes the binary total score,

---
 rtl/score_bcd_display_if.sv | 16 +
 rtl/score_bcd_display.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/score_bcd_display_if.sv
// Request/result bundle between the game FSM stages and the score display.
// The master drives update/score; the slave returns ready, overflow, bcd and hex.
interface score_bcd_display_if #(
    parameter int unsigned SCORE_BITWIDTH = 24,
    parameter int unsigned DIGITS         = 6
);
    logic                        update;
    logic [SCORE_BITWIDTH-1:0]   score;
    logic                        ready;
    logic                        overflow;
    logic [4*DIGITS-1:0]         bcd;
    logic [7*DIGITS-1:0]         hex;

    modport master (output update, score, input  ready, overflow, bcd, hex);
    modport slave  (input  update, score, output ready, overflow, bcd, hex);
endinterface

// File: rtl/score_bcd_display.sv
// Binary score to packed BCD (iterative shift-add-3) driving active-low HEX displays.
// Outputs hold the previous result until a new conversion completes.
module score_bcd_display #(
    parameter int unsigned SCORE_BITWIDTH = 24,
    parameter int unsigned DIGITS         = 6,
    parameter int unsigned BLANK_LEADING  = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    score_bcd_display_if.slave    bus
);
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned HEX_W = 7 * DIGITS;
    localparam int unsigned CMP_W = (SCORE_BITWIDTH > BCD_W) ? SCORE_BITWIDTH : BCD_W;
    localparam int unsigned CNT_W = (SCORE_BITWIDTH > 1) ? $clog2(SCORE_BITWIDTH) : 1;

    function automatic logic [CMP_W-1:0] calc_max();
        logic [CMP_W-1:0] m;
        m = CMP_W'(1);
        for (int unsigned i = 0; i < DIGITS; i++) m = m * CMP_W'(10);
        return m - CMP_W'(1);
    endfunction

    function automatic logic [HEX_W-1:0] calc_reset_hex();
        logic [HEX_W-1:0] h;
        h = '0;
        for (int unsigned i = 0; i < DIGITS; i++)
            h[7*i +: 7] = (i == 0 || BLANK_LEADING == 0) ? 7'h40 : 7'h7F;
        return h;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    localparam logic [CMP_W-1:0] SCORE_MAX = calc_max();
    localparam logic [HEX_W-1:0] RESET_HEX = calc_reset_hex();

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;

    state_t                    state_q, state_d;
    logic                      update_prev_q, update_prev_d;
    logic                      ready_q, ready_d;
    logic                      ovf_pend_q, ovf_pend_d;
    logic                      overflow_q, overflow_d;
    logic [SCORE_BITWIDTH-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]          acc_q, acc_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [BCD_W-1:0]          bcd_q, bcd_d;
    logic [HEX_W-1:0]          hex_q, hex_d;

    logic [BCD_W-1:0]          adj_c;
    logic [HEX_W-1:0]          hex_c;

    // Add-3 correction on every nibble ahead of the shift
    always_comb begin : adj_blk
        logic [3:0] nib;
        nib   = '0;
        adj_c = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            nib = acc_q[4*i +: 4];
            adj_c[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
    end

    // Segment decode with leading-zero blanking, scanning from the top digit down
    always_comb begin : seg_blk
        logic       all_zero;
        logic [3:0] nib;
        all_zero = 1'b1;
        nib      = '0;
        hex_c    = '0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            nib      = acc_q[4*i +: 4];
            all_zero = all_zero && (nib == 4'd0);
            if (i != 0 && BLANK_LEADING != 0 && all_zero) hex_c[7*i +: 7] = 7'h7F;
            else                                          hex_c[7*i +: 7] = seg7(nib);
        end
    end

    always_comb begin
        state_d       = state_q;
        update_prev_d = bus.update;
        ready_d       = ready_q;
        ovf_pend_d    = ovf_pend_q;
        overflow_d    = overflow_q;
        bin_d         = bin_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        bcd_d         = bcd_q;
        hex_d         = hex_q;
        case (state_q)
            IDLE: begin
                if (bus.update && !update_prev_q) begin
                    bin_d   = bus.score;
                    ready_d = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                acc_d = '0;
                cnt_d = '0;
                if (CMP_W'(bin_q) > SCORE_MAX) begin
                    bin_d      = SCORE_BITWIDTH'(SCORE_MAX);
                    ovf_pend_d = 1'b1;
                end else begin
                    ovf_pend_d = 1'b0;
                end
                state_d = SHIFT;
            end
            SHIFT: begin
                {acc_d, bin_d} = {adj_c, bin_q} << 1;
                cnt_d          = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(SCORE_BITWIDTH - 1)) state_d = LATCH;
            end
            LATCH: begin
                bcd_d      = acc_q;
                hex_d      = hex_c;
                overflow_d = ovf_pend_q;
                ready_d    = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            update_prev_q <= 1'b0;
            ready_q       <= 1'b1;
            ovf_pend_q    <= 1'b0;
            overflow_q    <= 1'b0;
            bin_q         <= '0;
            acc_q         <= '0;
            cnt_q         <= '0;
            bcd_q         <= '0;
            hex_q         <= RESET_HEX;
        end else begin
            state_q       <= state_d;
            update_prev_q <= update_prev_d;
            ready_q       <= ready_d;
            ovf_pend_q    <= ovf_pend_d;
            overflow_q    <= overflow_d;
            bin_q         <= bin_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            bcd_q         <= bcd_d;
            hex_q         <= hex_d;
        end
    end

    assign bus.ready    = ready_q;
    assign bus.overflow = overflow_q;
    assign bus.bcd      = bcd_q;
    assign bus.hex      = hex_q;
endmodule
